// File: rtl/fetch_branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch target buffer:
// 2-bit saturating counter type, its encodings, the taken threshold
// and the value a newly allocated entry starts with.
package fetch_branch_predictor_pkg;

    typedef logic [1:0] bp_counter_t;

    localparam bp_counter_t BP_CNT_STRONG_NT   = 2'd0;
    localparam bp_counter_t BP_CNT_WEAK_NT     = 2'd1;
    localparam bp_counter_t BP_CNT_WEAK_T      = 2'd2;
    localparam bp_counter_t BP_CNT_STRONG_T    = 2'd3;

    // Counter values at or above this predict taken.
    localparam bp_counter_t BP_TAKEN_THRESHOLD = 2'd2;
    // A freshly allocated entry starts weakly taken.
    localparam bp_counter_t BP_ALLOC_VALUE     = 2'd2;

    function automatic logic bp_is_taken(input bp_counter_t cnt);
        return (cnt >= BP_TAKEN_THRESHOLD);
    endfunction

endpackage

// File: rtl/fetch_branch_predictor_counter.sv
// Next-state function of a 2-bit saturating branch counter:
// counts up on taken (saturating at strong-taken) and down on
// not-taken (saturating at strong-not-taken). Purely combinational.
module fetch_branch_predictor_counter
    import fetch_branch_predictor_pkg::*;
(
    input  logic [1:0] iCOUNTER,
    input  logic       iTAKEN,
    output logic [1:0] oCOUNTER
);

    // Saturating increment / decrement of the counter.
    always_comb begin
        oCOUNTER = iCOUNTER;
        if (iTAKEN) begin
            if (iCOUNTER != BP_CNT_STRONG_T) begin
                oCOUNTER = iCOUNTER + 2'd1;
            end
        end else begin
            if (iCOUNTER != BP_CNT_STRONG_NT) begin
                oCOUNTER = iCOUNTER - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped branch target buffer with
// a tag, target and 2-bit saturating counter per entry.
// Lookups are captured on one edge and presented registered on the next;
// resolved branches from execute update the table and hit/miss statistics.
// Build option MIST32E10FA_BTB_BYPASS_EN: when defined, a lookup captured in
// the same cycle as an update to the same index sees the updated entry;
// otherwise it sees the entry as it was before the update.
module fetch_branch_predictor
    import fetch_branch_predictor_pkg::*;
#(
    parameter int P_INDEX_W = 6
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iSTATE_NORMAL,
    input  logic        iFETCH_REQ,
    input  logic [31:0] iFETCH_ADDR,
    input  logic        iFETCH_BUSY,
    input  logic        iFLUSH,
    output logic        oPREDICT_VALID,
    output logic        oPREDICT_ENA,
    output logic [31:0] oPREDICT_ADDR,
    input  logic        iUPDATE_VALID,
    input  logic [31:0] iUPDATE_ADDR,
    input  logic        iUPDATE_TAKEN,
    input  logic [31:0] iUPDATE_TARGET,
    input  logic        iUPDATE_PREDICT_HIT,
    output logic [31:0] oHIT_COUNT,
    output logic [31:0] oMISS_COUNT
);

    localparam int LP_ENTRIES = 1 << P_INDEX_W;
    localparam int LP_TAG_W   = 32 - P_INDEX_W - 2;

    // Table storage. Valid and counter are reset; tag and target are
    // masked by valid and therefore left unreset.
    logic              r_valid   [LP_ENTRIES];
    bp_counter_t       r_counter [LP_ENTRIES];
    logic [LP_TAG_W-1:0] r_tag   [LP_ENTRIES];
    logic [31:0]       r_target  [LP_ENTRIES];

    // Registered lookup result.
    logic        r_predict_valid;
    logic        r_predict_ena;
    logic [31:0] r_predict_addr;
    logic        w_predict_valid_next;
    logic        w_predict_ena_next;
    logic [31:0] w_predict_addr_next;

    // Statistics.
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Update-side decode.
    logic [P_INDEX_W-1:0] w_upd_idx;
    logic [LP_TAG_W-1:0]  w_upd_tag;
    logic                 w_upd_en;
    logic                 w_upd_hit;
    logic [1:0]           w_cnt_stepped;
    logic                 w_wr_en;
    logic [31:0]          w_wr_target;
    bp_counter_t          w_wr_counter;

    // Lookup-side decode.
    logic [P_INDEX_W-1:0] w_rd_idx;
    logic [LP_TAG_W-1:0]  w_rd_tag;
    logic                 w_bypass;
    logic                 w_view_valid;
    logic [LP_TAG_W-1:0]  w_view_tag;
    logic [31:0]          w_view_target;
    bp_counter_t          w_view_counter;
    logic                 w_lookup_hit;
    logic                 w_capture;

    // Byte-offset bits of word-aligned PCs carry no information.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{iFETCH_ADDR[1:0], iUPDATE_ADDR[1:0]};

    assign w_upd_idx = iUPDATE_ADDR[P_INDEX_W+1:2];
    assign w_upd_tag = iUPDATE_ADDR[31:P_INDEX_W+2];
    assign w_rd_idx  = iFETCH_ADDR[P_INDEX_W+1:2];
    assign w_rd_tag  = iFETCH_ADDR[31:P_INDEX_W+2];

    // Reset overrides any update presented in the same cycle.
    assign w_upd_en  = iUPDATE_VALID && iSTATE_NORMAL && !iRESET_SYNC;
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    fetch_branch_predictor_counter u_counter (
        .iCOUNTER (r_counter[w_upd_idx]),
        .iTAKEN   (iUPDATE_TAKEN),
        .oCOUNTER (w_cnt_stepped)
    );

    // A hit always rewrites the entry (counter step, target on taken);
    // a miss only allocates when the branch was taken.
    assign w_wr_en      = w_upd_en && (w_upd_hit || iUPDATE_TAKEN);
    assign w_wr_target  = iUPDATE_TAKEN ? iUPDATE_TARGET : r_target[w_upd_idx];
    assign w_wr_counter = w_upd_hit ? bp_counter_t'(w_cnt_stepped) : BP_ALLOC_VALUE;

    // Per-entry valid bit and counter, cleared by reset.
    generate
        for (genvar gi = 0; gi < LP_ENTRIES; gi++) begin : g_entry
            localparam logic [P_INDEX_W-1:0] LP_IDX = P_INDEX_W'(gi);
            // Write this entry's valid and counter when the update targets it.
            always_ff @(posedge iCLOCK) begin
                if (iRESET_SYNC) begin
                    r_valid[gi]   <= 1'b0;
                    r_counter[gi] <= BP_CNT_STRONG_NT;
                end else if (w_wr_en && (w_upd_idx == LP_IDX)) begin
                    r_valid[gi]   <= 1'b1;
                    r_counter[gi] <= w_wr_counter;
                end
            end
        end
    endgenerate

    // Tag and target storage; written alongside valid/counter, never reset.
    always_ff @(posedge iCLOCK) begin
        if (w_wr_en) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= w_wr_target;
        end
    end

`ifdef MIST32E10FA_BTB_BYPASS_EN
    assign w_bypass = w_wr_en && (w_upd_idx == w_rd_idx);
`else
    assign w_bypass = 1'b0;
`endif

    // Entry as seen by the lookup: either stored contents or the
    // value being written this cycle when forwarding is enabled.
    always_comb begin
        w_view_valid   = r_valid[w_rd_idx];
        w_view_tag     = r_tag[w_rd_idx];
        w_view_target  = r_target[w_rd_idx];
        w_view_counter = r_counter[w_rd_idx];
        if (w_bypass) begin
            w_view_valid   = 1'b1;
            w_view_tag     = w_upd_tag;
            w_view_target  = w_wr_target;
            w_view_counter = w_wr_counter;
        end
    end

    assign w_lookup_hit = w_view_valid && (w_view_tag == w_rd_tag) &&
                          bp_is_taken(w_view_counter) && iSTATE_NORMAL;
    assign w_capture    = iFETCH_REQ && !iFETCH_BUSY && !iFLUSH;

    // Next lookup result: flush clears, busy holds, a capture loads, idle clears.
    always_comb begin
        w_predict_valid_next = 1'b0;
        w_predict_ena_next   = 1'b0;
        w_predict_addr_next  = 32'h0;
        if (iFLUSH) begin
            w_predict_valid_next = 1'b0;
        end else if (iFETCH_BUSY) begin
            w_predict_valid_next = r_predict_valid;
            w_predict_ena_next   = r_predict_ena;
            w_predict_addr_next  = r_predict_addr;
        end else if (w_capture) begin
            w_predict_valid_next = 1'b1;
            w_predict_ena_next   = w_lookup_hit;
            w_predict_addr_next  = w_lookup_hit ? w_view_target : 32'h0;
        end
    end

    // Lookup result register.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_predict_valid <= 1'b0;
            r_predict_ena   <= 1'b0;
            r_predict_addr  <= 32'h0;
        end else begin
            r_predict_valid <= w_predict_valid_next;
            r_predict_ena   <= w_predict_ena_next;
            r_predict_addr  <= w_predict_addr_next;
        end
    end

    // Resolved-branch statistics, wrapping naturally at 2**32.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else if (w_upd_en) begin
            if (iUPDATE_PREDICT_HIT) begin
                r_hit_count  <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign oPREDICT_VALID = r_predict_valid;
    assign oPREDICT_ENA   = r_predict_ena;
    assign oPREDICT_ADDR  = r_predict_addr;
    assign oHIT_COUNT     = r_hit_count;
    assign oMISS_COUNT    = r_miss_count;

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Testbench for fetch_branch_predictor: directed scenarios plus a
// randomized run, all compared against a table-level reference model.
module tb_fetch_branch_predictor;

    localparam int IW = 6;
    localparam int N  = 1 << IW;

    logic        clk = 1'b0;
    logic        rst, normal, req, busy, flush;
    logic [31:0] fetch_addr;
    logic        upd_valid, upd_taken, upd_hit;
    logic [31:0] upd_addr, upd_target;
    logic        o_valid, o_ena;
    logic [31:0] o_addr, o_hit, o_miss;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_cnt    [N];
    logic        e_valid, e_ena;
    logic [31:0] e_addr, e_hit, e_miss;

    always #5 clk = ~clk;

    fetch_branch_predictor #(.P_INDEX_W(IW)) dut (
        .iCLOCK              (clk),
        .iRESET_SYNC         (rst),
        .iSTATE_NORMAL       (normal),
        .iFETCH_REQ          (req),
        .iFETCH_ADDR         (fetch_addr),
        .iFETCH_BUSY         (busy),
        .iFLUSH              (flush),
        .oPREDICT_VALID      (o_valid),
        .oPREDICT_ENA        (o_ena),
        .oPREDICT_ADDR       (o_addr),
        .iUPDATE_VALID       (upd_valid),
        .iUPDATE_ADDR        (upd_addr),
        .iUPDATE_TAKEN       (upd_taken),
        .iUPDATE_TARGET      (upd_target),
        .iUPDATE_PREDICT_HIT (upd_hit),
        .oHIT_COUNT          (o_hit),
        .oMISS_COUNT         (o_miss)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & (N - 1));
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> (IW + 2);
    endfunction

    function automatic bit m_predicts(input logic [31:0] a);
        int i;
        i = idx_of(a);
        return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_cnt[i] >= 2);
    endfunction

    task automatic model_update();
        int i;
        if (upd_valid && normal) begin
            if (upd_hit) e_hit = e_hit + 1; else e_miss = e_miss + 1;
            i = idx_of(upd_addr);
            if (m_valid[i] && m_tag[i] == tag_of(upd_addr)) begin
                if (upd_taken) begin
                    m_cnt[i]    = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                    m_target[i] = upd_target;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(upd_addr);
                m_target[i] = upd_target;
                m_cnt[i]    = 2;
            end
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic nv, ne;
        logic [31:0] na;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_cnt[i]   = 0;
            end
            e_valid = 0; e_ena = 0; e_addr = 0; e_hit = 0; e_miss = 0;
            return;
        end
`ifdef MIST32E10FA_BTB_BYPASS_EN
        model_update();
`endif
        nv = 0; ne = 0; na = 0;
        if (flush) begin
            nv = 0;
        end else if (busy) begin
            nv = e_valid; ne = e_ena; na = e_addr;
        end else if (req) begin
            nv = 1;
            ne = normal && m_predicts(fetch_addr);
            na = ne ? m_target[idx_of(fetch_addr)] : 32'h0;
        end
`ifndef MIST32E10FA_BTB_BYPASS_EN
        model_update();
`endif
        e_valid = nv; e_ena = ne; e_addr = na;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; normal = 1; req = 0; busy = 0; flush = 0; fetch_addr = 0;
        upd_valid = 0; upd_addr = 0; upd_taken = 0; upd_target = 0; upd_hit = 0;
    endtask

    task automatic lookup(input logic [31:0] a);
        idle(); req = 1; fetch_addr = a;
        tick();
    endtask

    task automatic update(input logic [31:0] a, input logic tk, input logic [31:0] tg, input logic h);
        idle(); upd_valid = 1; upd_addr = a; upd_taken = tk; upd_target = tg; upd_hit = h;
        tick();
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        tick(); tick();
        checks++;
        if ({o_valid, o_ena, o_addr, o_hit, o_miss} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset got v=%0b e=%0b a=%h hit=%0d miss=%0d want all 0", o_valid, o_ena, o_addr, o_hit, o_miss);
        end
        $display("reset: v=%0b e=%0b a=%h", o_valid, o_ena, o_addr);
    endtask

    task automatic test_lookup_empty();
        lookup(32'h0000_1000);
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL lookup_empty got v=%0b e=%0b a=%h want v=1 e=0 a=0", o_valid, o_ena, o_addr);
        end
        $display("lookup 0x1000 empty: v=%0b e=%0b a=%h", o_valid, o_ena, o_addr);
        idle(); tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_clears_valid got %0b want 0", o_valid);
        end
    endtask

    task automatic test_allocate();
        update(32'h1000, 1'b1, 32'h2000, 1'b0);
        lookup(32'h1000);
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b1, 1'b1, 32'h2000}) begin
            errors++;
            $display("FAIL alloc_hit got v=%0b e=%0b a=%h want v=1 e=1 a=2000", o_valid, o_ena, o_addr);
        end
        $display("lookup 0x1000 after alloc: e=%0b a=%h", o_ena, o_addr);
        lookup(32'h1100);
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL alias_tag got v=%0b e=%0b a=%h want v=1 e=0 a=0", o_valid, o_ena, o_addr);
        end
        $display("lookup 0x1100 alias: e=%0b a=%h", o_ena, o_addr);
    endtask

    task automatic test_saturation();
        logic exp_ena [6];
        logic tk [6];
        // two taken (stay at 3), three not-taken (2,1,0), one taken (1)
        tk = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_ena = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            update(32'h1000, tk[k], 32'h2000, 1'b1);
            lookup(32'h1000);
            checks++;
            if (o_ena !== exp_ena[k] || o_ena !== e_ena || o_addr !== e_addr) begin
                errors++;
                $display("FAIL saturation_%0d got e=%0b a=%h want e=%0b a=%h", k, o_ena, o_addr, exp_ena[k], e_addr);
            end
            $display("saturation step %0d taken=%0b: e=%0b a=%h", k, tk[k], o_ena, o_addr);
        end
    endtask

    task automatic test_same_cycle();
        logic        want_e;
        logic [31:0] want_a;
`ifdef MIST32E10FA_BTB_BYPASS_EN
        want_e = 1'b1; want_a = 32'h4000;
`else
        want_e = 1'b0; want_a = 32'h0;
`endif
        idle();
        req = 1; fetch_addr = 32'h3000;
        upd_valid = 1; upd_addr = 32'h3000; upd_taken = 1; upd_target = 32'h4000; upd_hit = 0;
        tick();
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b1, want_e, want_a}) begin
            errors++;
            $display("FAIL same_cycle got v=%0b e=%0b a=%h want v=1 e=%0b a=%h", o_valid, o_ena, o_addr, want_e, want_a);
        end
        $display("same-cycle update+lookup 0x3000: e=%0b a=%h", o_ena, o_addr);
        lookup(32'h3000);
        checks++;
        if ({o_ena, o_addr} !== {1'b1, 32'h4000}) begin
            errors++;
            $display("FAIL after_same_cycle got e=%0b a=%h want e=1 a=4000", o_ena, o_addr);
        end
    endtask

    task automatic test_busy_flush();
        lookup(32'h3000);
        for (int k = 0; k < 3; k++) begin
            idle(); busy = 1; req = 1; fetch_addr = 32'h1000;
            tick();
            checks++;
            if ({o_valid, o_ena, o_addr} !== {1'b1, 1'b1, 32'h4000}) begin
                errors++;
                $display("FAIL busy_hold_%0d got v=%0b e=%0b a=%h want v=1 e=1 a=4000", k, o_valid, o_ena, o_addr);
            end
            $display("busy cycle %0d: v=%0b e=%0b a=%h", k, o_valid, o_ena, o_addr);
        end
        idle(); busy = 1; flush = 1; req = 1; fetch_addr = 32'h3000;
        tick();
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL flush_clear got v=%0b e=%0b a=%h want all 0", o_valid, o_ena, o_addr);
        end
        $display("after flush: v=%0b e=%0b a=%h", o_valid, o_ena, o_addr);
        lookup(32'h3000);
        checks++;
        if (o_ena !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_table got e=%0b want 1", o_ena);
        end
    endtask

    task automatic test_reset_mid();
        idle(); rst = 1; req = 1; fetch_addr = 32'h3000;
        upd_valid = 1; upd_addr = 32'h5000; upd_taken = 1; upd_target = 32'h6000; upd_hit = 1;
        tick();
        checks++;
        if ({o_valid, o_ena, o_addr, o_hit, o_miss} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid got v=%0b e=%0b a=%h hit=%0d miss=%0d want all 0", o_valid, o_ena, o_addr, o_hit, o_miss);
        end
        lookup(32'h3000);
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_clears_table got v=%0b e=%0b a=%h want v=1 e=0 a=0", o_valid, o_ena, o_addr);
        end
        lookup(32'h5000);
        checks++;
        if (o_ena !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_update got e=%0b want 0", o_ena);
        end
        $display("reset mid-operation: e=%0b", o_ena);
    endtask

    task automatic test_stats();
        for (int k = 0; k < 7; k++) begin
            update(32'h0000_8000 + 32'(k * 4), 1'b0, 32'h0, (k < 5) ? 1'b1 : 1'b0);
        end
        checks++;
        if (o_hit !== 32'd5 || o_miss !== 32'd2) begin
            errors++;
            $display("FAIL stats got hit=%0d miss=%0d want hit=5 miss=2", o_hit, o_miss);
        end
        $display("stats: hit=%0d miss=%0d", o_hit, o_miss);
    endtask

    task automatic test_not_normal();
        update(32'h0000_A000, 1'b1, 32'h0000_B000, 1'b1);
        idle(); normal = 0; req = 1; fetch_addr = 32'h0000_A000;
        upd_valid = 1; upd_addr = 32'h0000_C000; upd_taken = 1; upd_target = 32'h0000_D000; upd_hit = 1;
        tick();
        checks++;
        if ({o_valid, o_ena, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL not_normal_lookup got v=%0b e=%0b a=%h want v=1 e=0 a=0", o_valid, o_ena, o_addr);
        end
        lookup(32'h0000_C000);
        checks++;
        if (o_ena !== 1'b0 || o_hit !== 32'd6 || o_miss !== 32'd2) begin
            errors++;
            $display("FAIL not_normal_update got e=%0b hit=%0d miss=%0d want e=0 hit=6 miss=2", o_ena, o_hit, o_miss);
        end
        $display("not-normal: e=%0b hit=%0d miss=%0d", o_ena, o_hit, o_miss);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] t, i, lo;
        t  = $urandom_range(0, 2);
        i  = $urandom_range(0, 3);
        lo = $urandom_range(0, 3);
        return (t << (IW + 2)) | (i << 2) | lo;
    endfunction

    task automatic test_random();
        int errs_before;
        errs_before = errors;
        for (int n = 0; n < 400; n++) begin
            idle();
            rst        = ($urandom_range(0, 49) == 0);
            normal     = ($urandom_range(0, 9) != 0);
            req        = 1'($urandom_range(0, 1));
            busy       = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            fetch_addr = rand_addr();
            upd_valid  = 1'($urandom_range(0, 1));
            upd_addr   = rand_addr();
            upd_taken  = ($urandom_range(0, 2) != 0);
            upd_target = $urandom & 32'hFFFF_FFFC;
            upd_hit    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) fetch_addr = upd_addr;
            tick();
            checks++;
            if ({o_valid, o_ena, o_addr, o_hit, o_miss} !== {e_valid, e_ena, e_addr, e_hit, e_miss}) begin
                errors++;
                $display("FAIL random_%0d got v=%0b e=%0b a=%h hit=%0d miss=%0d want v=%0b e=%0b a=%h hit=%0d miss=%0d",
                         n, o_valid, o_ena, o_addr, o_hit, o_miss, e_valid, e_ena, e_addr, e_hit, e_miss);
            end
        end
        $display("random: 400 cycles, %0d new errors", errors - errs_before);
    endtask

    initial begin
        idle();
        e_valid = 0; e_ena = 0; e_addr = 0; e_hit = 0; e_miss = 0;
        test_reset();
        test_lookup_empty();
        test_allocate();
        test_saturation();
        test_same_cycle();
        test_busy_flush();
        test_reset_mid();
        test_stats();
        test_not_normal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
